digit_scan_mux: RTL and testbench
=================================

// Module: digit_scan_mux
// PURPOSE
//   Time-multiplexed scanner for the 4-digit 7-segment display. Sits directly upstream of the
//   7-segment decoder: it selects one BCD digit at a time, drives that digit's code on COUNT
//   for the decoder and drives the matching anode select on SA.
//   It also applies a per-digit enable mask, optional leading-zero blanking and an anti-ghost
//   gap. Display data is snapshotted once per frame so a digit never tears mid-scan.
// PARAMETERS
//   DIV  50000  clock cycles per digit slot (50 MHz -> 1 kHz per digit, 250 Hz frame); DIV >= GAP+2
//   GAP  500    cycles at the start of each slot with all SA off (anti-ghost); GAP >= 1
// PORTS
//   CLK        in   1   system clock
//   RST        in   1   reset, synchronous, active-high
//   DIGITS     in   16  BCD digits; [3:0]=digit0 (rightmost) .. [15:12]=digit3 (leftmost)
//   DP_IN      in   4   decimal point request per digit, bit i = digit i
//   EN         in   4   digit enable mask, bit i = 1 -> digit i may light
//   LZB        in   1   1 = blank leading zeros
//   COUNT      out  4   BCD code of the digit currently scanned, to the decoder's COUNT
//   DP         out  1   decimal point for the scanned digit, active-high
//   SA         out  4   anode select, one-hot, active-high; all 0 = dark
//   SCAN_TICK  out  1   one-cycle pulse at the end of each full frame
// BEHAVIOUR
//   - Clock and reset: one clock CLK. RST is synchronous and active-high, sampled on the CLK edge.
//   - Reset values: pcnt=0, idx=0, snapshot regs=0, COUNT=0, DP=0, SA=4'b0000, SCAN_TICK=0.
//   - Slot timing:
//     - pcnt counts 0..DIV-1.
//     - At the edge where pcnt==DIV-1: pcnt<=0 and idx<=idx+1, with 3 wrapping to 0 (scan 0,1,2,3,0...).
//   - Snapshot:
//     - At the edge where pcnt==0 && idx==0, register DIGITS, DP_IN, EN and LZB into the snapshot regs.
//     - This includes the first cycle after reset.
//     - Input changes at any other time have no effect until the next frame start.
//   - Visibility of digit i:
//     - Visible if snapEN[i]=1, and not blanked by LZB.
//     - LZB blanking (only when snapLZB=1): digit i, for i in 3..1, is blanked when snapshot
//       digits i..3 are all 4'h0. Digit 0 is never LZB-blanked.
//   - Outputs: all registered, computed from the current-cycle pcnt/idx/snapshot (1-cycle latency):
//     - COUNT <= snapDIGITS[idx].
//     - DP <= snapDP[idx] & vis[idx] & (pcnt>=GAP).
//     - SA <= (pcnt>=GAP) ? (4'b0001<<idx) & {4{vis[idx]}} : 4'b0000.
//     - SCAN_TICK <= (pcnt==DIV-1 && idx==3).
//   - Ordering guarantee:
//     - COUNT changes only while SA==0.
//     - SA is never multi-hot.
//     - SA asserts no earlier than the same edge at which COUNT becomes valid for the slot.
//   - Non-BCD codes (A..F) pass through unchanged; the decoder shows them as its error glyph.
//     They count as non-zero for LZB.
//   - Reset mid-slot or mid-frame:
//     - The next edge with RST=1 forces the reset values.
//     - The scan restarts at digit 0, slot cycle 0, with a fresh snapshot.
// TESTING (bench uses DIV=8, GAP=2 unless stated)
//   - Reset: hold RST 3 cycles, release -> COUNT=0, SA=0, DP=0, SCAN_TICK=0 on the first post-reset
//     cycle. SA first = 4'b0001 at slot-0 pcnt 3 (output view).
//   - Scan order: DIGITS=16'h4321, EN=4'hF, LZB=0.
//     - COUNT walks 1,2,3,4.
//     - SA walks 0001,0010,0100,1000, each high for DIV-GAP=6 cycles, preceded by 2 dark cycles.
//     - SCAN_TICK is high exactly 1 cycle per 32.
//   - LZB: DIGITS=16'h0070, LZB=1 -> only SA 0010 and 0001 ever assert.
//     DIGITS=16'h0000, LZB=1 -> only 0001 asserts.
//     DIGITS=16'h0A00, LZB=1 -> digits 2..0 light.
//   - Snapshot: change DIGITS from 16'h1111 to 16'h9999 during slot 2.
//     - COUNT stays 1 for slots 2 and 3.
//     - COUNT shows 9 from slot 0 of the next frame.
//   - Mask and DP: EN=4'b0101, DP_IN=4'b1111 -> SA/DP assert only in slots 0 and 2.
//     COUNT still cycles through all 4 digits.
//   - Reset mid-operation: assert RST at slot 2, pcnt 5 -> the next cycle shows reset values.
//     After release the scan restarts at digit 0 with a fresh snapshot.

Source files
------------

// File: rtl/digit_scan_mux_if.sv
// Display bus between the digit source and the 7-segment scanner.
// The master side supplies digit data and display options.
// The slave side returns the scanned digit code, the decimal point,
// the anode select and the frame tick.
interface digit_scan_mux_if;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  en;
    logic        lzb;
    logic [3:0]  count;
    logic        dp;
    logic [3:0]  sa;
    logic        scan_tick;

    modport master (
        output digits, dp_in, en, lzb,
        input  count, dp, sa, scan_tick
    );

    modport slave (
        input  digits, dp_in, en, lzb,
        output count, dp, sa, scan_tick
    );
endinterface

// File: rtl/digit_scan_mux.sv
// Time-multiplexed scanner for a 4-digit 7-segment display.
// Each digit owns a slot of DIV cycles. The first GAP cycles of every slot
// keep all anodes dark, so that a COUNT change never ghosts onto the
// neighbouring digit. The display inputs are snapshotted once per frame,
// at slot 0 / cycle 0, so a frame never mixes old and new data.
module digit_scan_mux #(
    parameter int DIV = 50000,
    parameter int GAP = 500
) (
    input  logic             i_clk,
    input  logic             i_rst,
    digit_scan_mux_if.slave  bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] r_pcnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_snap_digits;
    logic [3:0]    r_snap_dp;
    logic [3:0]    r_snap_en;
    logic          r_snap_lzb;
    logic [3:0]    r_count;
    logic          r_dp;
    logic [3:0]    r_sa;
    logic          r_scan_tick;

    logic          w_slot_end;
    logic          w_frame_start;
    logic          w_lit;
    logic          w_nz3;
    logic          w_nz2;
    logic          w_nz1;
    logic [3:0]    w_vis;
    logic [3:0]    w_cur_digit;
    logic          w_cur_vis;
    logic [3:0]    w_cur_sa;

    assign w_slot_end    = (r_pcnt == PW'(DIV - 1));
    assign w_frame_start = (r_pcnt == '0) && (r_idx == 2'd0);
    assign w_lit         = (r_pcnt >= PW'(GAP));

    // A digit is a leading zero when it and every digit to its left are zero.
    // Digit 0 always shows, so that a value of 0 still displays as "0".
    assign w_nz3 = |r_snap_digits[15:12];
    assign w_nz2 = w_nz3 | (|r_snap_digits[11:8]);
    assign w_nz1 = w_nz2 | (|r_snap_digits[7:4]);
    assign w_vis = r_snap_en & {~r_snap_lzb | w_nz3,
                                ~r_snap_lzb | w_nz2,
                                ~r_snap_lzb | w_nz1,
                                1'b1};

    assign w_cur_digit = r_snap_digits[{r_idx, 2'b00} +: 4];
    assign w_cur_vis   = w_vis[r_idx];
    assign w_cur_sa    = (4'b0001 << r_idx) & {4{w_cur_vis & w_lit}};

    // Slot timer and digit index: idx advances on the last cycle of each slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pcnt <= '0;
            r_idx  <= 2'd0;
        end else if (w_slot_end) begin
            r_pcnt <= '0;
            r_idx  <= r_idx + 2'd1;
        end else begin
            r_pcnt <= r_pcnt + PW'(1);
        end
    end

    // Frame snapshot of the display inputs, taken only at the start of a frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_snap_digits <= '0;
            r_snap_dp     <= '0;
            r_snap_en     <= '0;
            r_snap_lzb    <= 1'b0;
        end else if (w_frame_start) begin
            r_snap_digits <= bus.digits;
            r_snap_dp     <= bus.dp_in;
            r_snap_en     <= bus.en;
            r_snap_lzb    <= bus.lzb;
        end
    end

    // Registered display outputs. They are driven from the current slot state,
    // so COUNT settles during the dark gap, before SA turns on.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count     <= 4'd0;
            r_dp        <= 1'b0;
            r_sa        <= 4'b0000;
            r_scan_tick <= 1'b0;
        end else begin
            r_count     <= w_cur_digit;
            r_dp        <= r_snap_dp[r_idx] & w_cur_vis & w_lit;
            r_sa        <= w_cur_sa;
            r_scan_tick <= w_slot_end && (r_idx == 2'd3);
        end
    end

    assign bus.count     = r_count;
    assign bus.dp        = r_dp;
    assign bus.sa        = r_sa;
    assign bus.scan_tick = r_scan_tick;
endmodule

// File: tb/tb_digit_scan_mux.sv
module tb_digit_scan_mux;
    localparam int DIV   = 8;
    localparam int GAP   = 2;
    localparam int FRAME = 4 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    digit_scan_mux_if bus ();

    digit_scan_mux #(.DIV(DIV), .GAP(GAP)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the outputs after non-reset edge number n, derived from
    // the absolute cycle number and the frame's captured inputs.
    function automatic bit vis_of(input logic [15:0] d, input logic [3:0] en,
                                  input logic lzb, input int i);
        bit any;
        if (!en[i]) return 1'b0;
        if (!lzb || i == 0) return 1'b1;
        any = 1'b0;
        for (int j = i; j < 4; j++)
            if (d[4*j +: 4] != 4'h0) any = 1'b1;
        return any;
    endfunction

    int          n;
    bit          model_valid = 1'b0;
    logic [15:0] sd;
    logic [3:0]  sdp, sen;
    logic        slzb;
    logic [3:0]  e_count, e_sa;
    logic        e_dp, e_tick;
    int          mp, mi;
    bit          mv;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            n = 0; sd = '0; sdp = '0; sen = '0; slzb = 1'b0;
            e_count = '0; e_sa = '0; e_dp = 1'b0; e_tick = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            mp = n % DIV;
            mi = (n / DIV) % 4;
            mv = vis_of(sd, sen, slzb, mi);
            e_count = sd[4*mi +: 4];
            e_sa    = (mp >= GAP && mv) ? (4'b0001 << mi) : 4'b0000;
            e_dp    = sdp[mi] && mv && (mp >= GAP);
            e_tick  = (mp == DIV - 1) && (mi == 3);
            if (n % FRAME == 0) begin
                sd = bus.digits; sdp = bus.dp_in; sen = bus.en; slzb = bus.lzb;
            end
            n++;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            check("count", bus.count, e_count);
            check("sa", bus.sa, e_sa);
            check("dp", {3'b000, bus.dp}, {3'b000, e_dp});
            check("scan_tick", {3'b000, bus.scan_tick}, {3'b000, e_tick});
        end
    end

    task automatic do_reset(input logic [15:0] d, input logic [3:0] dpi,
                            input logic [3:0] en, input logic lzb);
        @(negedge clk);
        rst = 1'b1;
        bus.digits = d; bus.dp_in = dpi; bus.en = en; bus.lzb = lzb;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] obs_sa_or;
    logic [3:0] obs_dp_slots;
    int         obs_ticks;
    int         obs_hi [4];
    logic [3:0] obs_mid [4];

    // Observes outputs after edges 0..FRAME-1 of a frame.
    task automatic observe_frame();
        obs_sa_or = '0; obs_dp_slots = '0; obs_ticks = 0;
        for (int s = 0; s < 4; s++) begin obs_hi[s] = 0; obs_mid[s] = '0; end
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            obs_sa_or = obs_sa_or | bus.sa;
            if (bus.dp) obs_dp_slots[k / DIV] = 1'b1;
            if (bus.scan_tick) obs_ticks++;
            for (int s = 0; s < 4; s++) if (bus.sa[s]) obs_hi[s]++;
            if (k % DIV == 4) obs_mid[k / DIV] = bus.count;
        end
    endtask

    initial begin
        bus.digits = '0; bus.dp_in = '0; bus.en = '0; bus.lzb = 1'b0;

        // Reset values and first anode timing
        do_reset(16'h4321, 4'h0, 4'hF, 1'b0);
        check("rst_count", bus.count, 4'h0);
        check("rst_sa", bus.sa, 4'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("post_rst_count", bus.count, 4'h0);
                check("post_rst_sa", bus.sa, 4'h0);
                check("post_rst_dp_tick", {2'b00, bus.dp, bus.scan_tick}, 4'h0);
            end
            if (k == 1) check("sa_gap_dark", bus.sa, 4'h0);
            if (k == 2) check("sa_first_on", bus.sa, 4'b0001);
        end

        // Scan order, slot widths, frame tick
        do_reset(16'h4321, 4'h0, 4'hF, 1'b0);
        observe_frame();
        for (int s = 0; s < 4; s++) begin
            check("scan_count", obs_mid[s], 4'(s + 1));
            check("sa_on_cycles", 4'(obs_hi[s]), 4'd6);
        end
        check("ticks_per_frame", 4'(obs_ticks), 4'd1);
        observe_frame();
        check("ticks_second_frame", 4'(obs_ticks), 4'd1);

        // Leading-zero blanking
        do_reset(16'h0070, 4'h0, 4'hF, 1'b1);
        observe_frame();
        check("lzb_0070", obs_sa_or, 4'b0011);
        do_reset(16'h0000, 4'h0, 4'hF, 1'b1);
        observe_frame();
        check("lzb_0000", obs_sa_or, 4'b0001);
        do_reset(16'h0A00, 4'h0, 4'hF, 1'b1);
        observe_frame();
        check("lzb_0A00", obs_sa_or, 4'b0111);

        // Enable mask and decimal point
        do_reset(16'h4321, 4'hF, 4'b0101, 1'b0);
        observe_frame();
        check("mask_sa", obs_sa_or, 4'b0101);
        check("mask_dp_slots", obs_dp_slots, 4'b0101);
        for (int s = 0; s < 4; s++) check("mask_count", obs_mid[s], 4'(s + 1));

        // Snapshot: mid-frame change takes effect next frame
        do_reset(16'h1111, 4'h0, 4'hF, 1'b0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 17) bus.digits = 16'h9999;
            if (k == 20) check("snap_slot2", bus.count, 4'h1);
            if (k == 28) check("snap_slot3", bus.count, 4'h1);
            if (k == 36) check("snap_next_frame", bus.count, 4'h9);
        end

        // Reset mid-slot
        do_reset(16'h5678, 4'hF, 4'hF, 1'b0);
        for (int k = 0; k <= 20; k++) @(negedge clk);
        rst = 1'b1;
        bus.digits = 16'h2468;
        @(negedge clk);
        check("midrst_count", bus.count, 4'h0);
        check("midrst_sa", bus.sa, 4'h0);
        check("midrst_dp", {3'b000, bus.dp}, 4'h0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) check("restart_sa", bus.sa, 4'b0001);
            if (k == 4) check("restart_count", bus.count, 4'h8);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
